// File: rtl/ysyx_23060096_pkg.sv
// Shared definitions for the ysyx_23060096 add/subtract unit.
//   OP_ADD/OP_SUB/OP_ADC/OP_SBC : 2-bit opcodes. Bit 0 selects subtract
//                                 (invert B). Bit 1 selects carry-chained
//                                 operation (carry-in from the previous op).
//   state_t                     : sequencer states, also exported for debug.
package ysyx_23060096_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ysyx_23060096_addsub_seq_if.sv
// Operand/result bus of the add/subtract unit.
//   in_valid/in_ready   : operand handshake (master -> unit)
//   in_a, in_b          : WIDTH-bit operands
//   in_op, in_sat       : opcode and signed-saturation enable
//   out_valid/out_ready : result handshake (unit -> master)
//   out_result          : WIDTH-bit result
//   out_zero/neg/overflow/carry : result flags
//
// Handshake rule for both directions: a transfer happens on a rising clock
// edge where valid && ready are both high. The sender keeps its payload
// stable while valid is high and ready is low; ready may be asserted
// regardless of valid.
interface ysyx_23060096_addsub_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             in_sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_neg;
  logic             out_overflow;
  logic             out_carry;

  modport master (
    output in_valid, in_a, in_b, in_op, in_sat, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_neg,
           out_overflow, out_carry
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_sat, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_neg,
           out_overflow, out_carry
  );
endinterface

// File: rtl/ysyx_23060096_addsub_seq_chunk_adder.sv
// Combinational CHUNK-bit adder slice, reused every cycle by the sequencer.
//   a, b : CHUNK-bit addends
//   cin  : carry in
//   sum  : CHUNK-bit sum
//   cout : carry out of the slice MSB
module ysyx_23060096_chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
endmodule

// File: rtl/ysyx_23060096_addsub_seq.sv
// Multi-cycle add/subtract unit. Processes one CHUNK-bit slice per cycle,
// supports ADD/SUB/ADC/SBC with a carry register chained between operations,
// and optional clamping to the signed range on overflow.
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   bus (slave)  : operand/result handshakes, result and flags
//   dbg_state_o  : current sequencer state
//   dbg_carry_o  : carry register (carry out of the last completed op)
module ysyx_23060096_addsub_seq
  import ysyx_23060096_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_23060096_addsub_seq_if.slave  bus,
  output state_t                     dbg_state_o,
  output logic                       dbg_carry_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SMAX = ~SMIN;

  if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("ysyx_23060096_addsub_seq: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;        // B already inverted for subtract
  logic [WIDTH-1:0]  res_q, res_d;
  logic              run_c_q;    // carry rippling between slices
  logic              sat_q;
  logic [IDXW-1:0]   idx_q;
  logic              carry_q;
  logic              zero_q, neg_q, ovf_q;

  logic              accept;
  logic              last_chunk;
  logic              cin_sel;
  logic [CHUNK-1:0]  a_sl, b_sl, sum_sl;
  logic              cout_sl;
  logic              ovf_d;
  logic [WIDTH-1:0]  final_res;

  assign accept     = bus.in_valid && bus.in_ready;
  assign last_chunk = (int'(idx_q) == NCHUNK - 1);

  // Initial carry: 0 for ADD, 1 for SUB (two's complement), chained for ADC/SBC.
  always_comb begin
    cin_sel = 1'b0;
    case (bus.in_op)
      OP_ADD:         cin_sel = 1'b0;
      OP_SUB:         cin_sel = 1'b1;
      OP_ADC, OP_SBC: cin_sel = carry_q;
      default:        cin_sel = 1'b0;
    endcase
  end

  assign a_sl = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign b_sl = b_q[int'(idx_q)*CHUNK +: CHUNK];

  ysyx_23060096_chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (run_c_q),
    .sum  (sum_sl),
    .cout (cout_sl)
  );

  // Result register with the current slice merged in; on the last slice this
  // is the complete raw sum used for the flags.
  always_comb begin
    res_d = res_q;
    res_d[int'(idx_q)*CHUNK +: CHUNK] = sum_sl;
  end

  assign ovf_d     = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
  assign final_res = (sat_q && ovf_d) ? (a_q[WIDTH-1] ? SMIN : SMAX) : res_d;

  // ---------------- sequencer ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last_chunk) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      run_c_q <= 1'b0;
      sat_q   <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b ^ {WIDTH{bus.in_op[0]}};
            sat_q   <= bus.in_sat;
            run_c_q <= cin_sel;
            idx_q   <= '0;
          end
        end
        BUSY: begin
          run_c_q <= cout_sl;
          idx_q   <= idx_q + 1'b1;
          if (last_chunk) begin
            res_q   <= final_res;
            carry_q <= cout_sl;
            ovf_q   <= ovf_d;
            zero_q  <= (final_res == '0);
            neg_q   <= final_res[WIDTH-1];
          end else begin
            res_q   <= res_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.out_result   = res_q;
  assign bus.out_zero     = zero_q;
  assign bus.out_neg      = neg_q;
  assign bus.out_overflow = ovf_q;
  assign bus.out_carry    = carry_q;

  assign dbg_state_o = state_q;
  assign dbg_carry_o = carry_q;

endmodule

// File: tb/tb_ysyx_23060096_addsub_seq.sv
module tb_ysyx_23060096_addsub_seq;
  import ysyx_23060096_pkg::*;

  localparam int W   = 32;
  localparam int NCH = 4;
  localparam longint SMAXL = 64'sd2147483647;
  localparam longint SMINL = -64'sd2147483648;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_23060096_addsub_seq_if #(.WIDTH(W)) bus ();
  state_t dbg_state;
  logic   dbg_carry;

  ysyx_23060096_addsub_seq #(.WIDTH(W), .CHUNK(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_carry_o (dbg_carry)
  );

  int checks = 0;
  int errors = 0;

  logic          tb_carry;    // model of the chained carry register
  logic [W-1:0]  got_res;
  logic          got_z, got_n, got_v, got_c;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic. Subtraction is a - b - borrow, where
  // borrow = !carry for SBC; overflow is "true signed result out of range".
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [1:0] op, input logic sat, input logic cprev,
                                output logic [W-1:0] res, output logic z, output logic n,
                                output logic v, output logic c);
    longint ua, ub, us, sa, sb, ss, k;
    logic [W-1:0] raw;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == OP_ADD || op == OP_ADC) begin
      k  = (op == OP_ADC) ? longint'(cprev) : 0;
      us = ua + ub + k;
      ss = sa + sb + k;
      c  = (us > 64'sd4294967295);
    end else begin
      k  = (op == OP_SBC) ? longint'(!cprev) : 0;
      us = ua - ub - k;
      ss = sa - sb - k;
      c  = (us >= 0);
    end
    raw = us[W-1:0];
    v   = (ss > SMAXL) || (ss < SMINL);
    if (sat && v) res = (ss > SMAXL) ? 32'h7FFF_FFFF : 32'h8000_0000;
    else          res = raw;
    z = (res == '0);
    n = res[W-1];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic release_out(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, " idle_out_valid"}, W'(bus.out_valid), '0);
    check({tag, " idle_in_ready"}, W'(bus.in_ready), W'(1));
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic sat, input bit hold);
    logic [W-1:0] er;
    logic ez, en, ev, ec;
    int cyc;
    model(a, b, op, sat, tb_carry, er, ez, en, ev, ec);
    @(negedge clk);
    check({tag, " in_ready"}, W'(bus.in_ready), W'(1));
    bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_sat = sat;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, W'(cyc), W'(NCH));
    got_res = bus.out_result; got_z = bus.out_zero; got_n = bus.out_neg;
    got_v = bus.out_overflow; got_c = bus.out_carry;
    check({tag, " result"}, got_res, er);
    check({tag, " flags_zncv"}, W'({got_z, got_n, got_c, got_v}), W'({ez, en, ec, ev}));
    tb_carry = ec;
    if (!hold) release_out(tag);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [W-1:0] specials [5];
    logic [W-1:0] ra, rb;
    specials[0] = 32'h0000_0000; specials[1] = 32'h0000_0001;
    specials[2] = 32'h7FFF_FFFF; specials[3] = 32'h8000_0000;
    specials[4] = 32'hFFFF_FFFF;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = OP_ADD;
    bus.in_sat = 1'b0; bus.out_ready = 1'b0;
    tb_carry = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst in_ready", W'(bus.in_ready), W'(1));
    check("rst out_valid", W'(bus.out_valid), '0);
    check("rst out_result", bus.out_result, '0);
    check("rst flags", W'({bus.out_zero, bus.out_neg, bus.out_overflow, bus.out_carry}), '0);
    check("rst state", W'(dbg_state), W'(IDLE));
    check("rst carry_q", W'(dbg_carry), '0);
    rst = 1'b0;

    // signed overflow on ADD
    do_op("add_ovf", 32'h7FFF_FFFF, 32'h1, OP_ADD, 1'b0, 1'b0);
    check("add_ovf lit_res", got_res, 32'h8000_0000);
    check("add_ovf lit_flags", W'({got_v, got_c, got_n, got_z}), W'(4'b1010));

    // SUB equal operands
    do_op("sub_eq", 32'd5, 32'd5, OP_SUB, 1'b0, 1'b0);
    check("sub_eq lit_res", got_res, '0);
    check("sub_eq lit_flags", W'({got_z, got_c, got_v}), W'(3'b110));

    // 64-bit chain
    do_op("chain_lo", 32'hFFFF_FFFF, 32'h1, OP_ADD, 1'b0, 1'b0);
    check("chain_lo lit", W'({got_res == '0, got_c}), W'(2'b11));
    do_op("chain_hi", 32'h0, 32'h0, OP_ADC, 1'b0, 1'b0);
    check("chain_hi lit_res", got_res, 32'h1);

    // saturating subtract and its unsaturated twin
    do_op("sub_sat", 32'h8000_0000, 32'h1, OP_SUB, 1'b1, 1'b0);
    check("sub_sat lit_res", got_res, 32'h8000_0000);
    check("sub_sat lit_ovf", W'(got_v), W'(1));
    do_op("sub_nosat", 32'h8000_0000, 32'h1, OP_SUB, 1'b0, 1'b0);
    check("sub_nosat lit_res", got_res, 32'h7FFF_FFFF);

    // backpressure: hold result 5 cycles while a stray op is offered
    do_op("bp", 32'h1234_5678, 32'h0FED_CBA9, OP_SBC, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_a = 32'hDEAD_BEEF; bus.in_b = 32'h1; bus.in_op = OP_ADD;
      @(negedge clk);
      check("bp hold_result", bus.out_result, got_res);
      check("bp hold_flags", W'({bus.out_zero, bus.out_neg, bus.out_overflow, bus.out_carry}),
            W'({got_z, got_n, got_v, got_c}));
      check("bp hold_valid_ready", W'({bus.out_valid, bus.in_ready}), W'(2'b10));
    end
    bus.in_valid = 1'b0;
    release_out("bp");
    check("bp state_idle", W'(dbg_state), W'(IDLE));
    do_op("bp_after", 32'h0000_0010, 32'h0000_0003, OP_ADC, 1'b0, 1'b0);

    // reset in the middle of BUSY with carry_q set beforehand
    do_op("pre_rst", 32'hFFFF_FFFF, 32'h2, OP_ADD, 1'b0, 1'b0);
    check("pre_rst carry_q", W'(dbg_carry), W'(1));
    @(negedge clk);
    bus.in_a = 32'h1234_5678; bus.in_b = 32'h1111_1111; bus.in_op = OP_ADD;
    bus.in_sat = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst state", W'(dbg_state), W'(IDLE));
    check("mid_rst valid_ready", W'({bus.out_valid, bus.in_ready}), W'(2'b01));
    check("mid_rst carry_q", W'(dbg_carry), '0);
    check("mid_rst result", bus.out_result, '0);
    @(negedge clk);
    rst = 1'b0;
    tb_carry = 1'b0;
    do_op("adc_after_rst", 32'h1, 32'h1, OP_ADC, 1'b0, 1'b0);
    check("adc_after_rst lit", got_res, 32'h2);

    // randomized operations, biased toward boundary operands
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 2) == 0) ra = specials[$urandom_range(0, 4)];
      if ($urandom_range(0, 2) == 0) rb = specials[$urandom_range(0, 4)];
      do_op($sformatf("rand%0d", i), ra, rb, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060096_addsub_seq.md
# ysyx_23060096_addsub_seq

Parametrised, multi-cycle signed/unsigned add/subtract unit for the NPC execute path, the successor to the fixed 4-bit combinational adder. It adds or subtracts `WIDTH`-bit operands one `CHUNK`-bit slice per cycle and supports carry-chained ADC/SBC for multi-word arithmetic and optional signed saturation. Each operation produces the result plus zero, negative, overflow and carry flags. Operands enter and results leave through valid/ready handshakes.

## Interface
- `WIDTH`, 32, operand/result width; must be a multiple of `CHUNK`.
- `CHUNK`, 8, bits processed per cycle; `NCHUNK = WIDTH/CHUNK`, must be ≥1.
- `clk` input 1 clock, rising edge.
- `rst` input 1 reset; asynchronous, active-high.
- `in_valid` input 1 operands valid.
- `in_ready` output 1 unit can accept an operation.
- `in_a` input WIDTH operand A.
- `in_b` input WIDTH operand B.
- `in_op` input 2 opcode: 00 ADD, 01 SUB, 10 ADC, 11 SBC.
- `in_sat` input 1 clamp result on signed overflow.
- `out_valid` output 1 result valid.
- `out_ready` input 1 consumer accepts result.
- `out_result` output WIDTH result.
- `out_zero` output 1 result == 0.
- `out_neg` output 1 result MSB.
- `out_overflow` output 1 signed overflow (pre-saturation).
- `out_carry` output 1 raw carry out of MSB.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, latch A, B' = B XOR {WIDTH{op[0]}}, op, sat. Latch cin = 0 (ADD), 1 (SUB), `carry_q` (ADC/SBC). Clear chunk index. Go to BUSY.
- BUSY: each cycle, add chunk `idx` of A, chunk `idx` of B', and the running carry. Write the slice into the result register and update the running carry. Increment `idx`. After chunk `NCHUNK-1`, go to DONE.
- DONE: outputs stable, `out_valid`=1. On `out_ready`, go to IDLE.
- Flags are computed once, on the transition into DONE:
  - carry = final running carry; for SUB/SBC, 1 means no borrow.
  - overflow = (A[MSB] == B'[MSB]) && (raw[MSB] != A[MSB]).
  - if sat && overflow: result = A[MSB] ? signed min : signed max. Otherwise result = raw.
  - zero and neg are taken from the final (post-saturation) result.
- `carry_q` is an internal register holding `out_carry` of the last completed op. It is updated on entry to DONE for every opcode.
- All arithmetic is modulo 2^WIDTH; there are no wider intermediates except the 1-bit carry.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_result`=0, all flags 0, `carry_q`=0, `idx`=0.
- Latency: accept at edge T; chunks are computed at edges T+1 … T+NCHUNK; `out_valid` rises after edge T+NCHUNK.
- Throughput: one op per NCHUNK+2 cycles with `out_ready` tied high. `in_ready` is high only in IDLE.
- `out_*` hold their values while `out_valid && !out_ready`. Inputs are ignored outside IDLE.
- Reset asserted mid-operation: the unit returns immediately to the reset values and the partial result is discarded. `carry_q` clears, so the next ADC behaves as ADD.
- NCHUNK=1: BUSY lasts one cycle. The same FSM applies.

## Structure
- Shared package `ysyx_23060096_pkg` holds:
  - opcode constants (`OP_ADD`, `OP_SUB`, `OP_ADC`, `OP_SBC`);
  - the FSM state typedef.
- Sub-module `ysyx_23060096_chunk_adder`: a combinational `CHUNK`-bit adder with inputs a, b, cin and outputs sum, cout. It is instantiated once and reused each cycle.
- Parameter legality is checked at elaboration.

## Test plan
- **ADD, WIDTH=32, CHUNK=8:** A=0x7FFF_FFFF, B=1 → after 4 BUSY cycles, result 0x8000_0000, overflow=1, carry=0, neg=1, zero=0.
- **SUB:** A=5, B=5 → result 0, zero=1, carry=1 (no borrow), overflow=0.
- **64-bit chain:** ADD 0xFFFF_FFFF+1, then ADC 0+0 → first result 0 with carry=1; second result 1.
- **SUB with saturation:** A=0x8000_0000, B=1, sat=1 → result 0x8000_0000, overflow=1. The same inputs with sat=0 give 0x7FFF_FFFF.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE → outputs stable, `in_ready`=0, a new `in_valid` is ignored. Release `out_ready` → back to IDLE the next cycle.
- **Reset mid-BUSY:** assert `rst` at chunk 2 of an ADD → `out_valid`=0, state IDLE, `carry_q`=0. A following ADC 1+1 yields 2.
